// File: rtl/sensor_frame_packetizer.sv
// Sensor sample packetizer: buffers 8-bit samples in a FIFO and emits fixed-length
// frames (header, sequence, samples, XOR checksum) over a start/busy byte interface.
module sensor_frame_packetizer #(
    parameter int         FRAME_LEN  = 4,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_valid,
    input  logic [7:0]                  sample_data,
    input  logic                        tx_busy,
    output logic                        tx_start,
    output logic [7:0]                  tx_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  drop_count,
    output logic                        frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEVEL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] FRAME_FILL  = LW'(FRAME_LEN);
    localparam logic [LW-1:0] LAST_SAMPLE = LW'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEQ,
        DATA,
        CSUM,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t        state;
    state_t        state_next;
    state_t        ret_state;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_next;
    logic [LW-1:0] sample_cnt;
    logic [7:0]    seq_cnt;
    logic [7:0]    csum;
    logic          full;
    logic          wr_en;
    logic          emit;
    logic          pop;
    logic          done_next;
    logic          wait_lo_exit;

    // Full is judged on the registered level, so a pop in the same cycle never frees a slot.
    assign full  = (fifo_level == LEVEL_FULL);
    assign wr_en = sample_valid && !full;

    assign emit = !tx_busy && (state == HDR || state == SEQ || state == DATA || state == CSUM);
    assign pop  = emit && (state == DATA);
    assign wait_lo_exit = (state == WAIT_LO) && !tx_busy;

    always_comb begin
        level_next = fifo_level;
        if (wr_en && !pop) begin
            level_next = fifo_level + 1'b1;
        end else if (!wr_en && pop) begin
            level_next = fifo_level - 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (level_next >= FRAME_FILL) begin
                    state_next = HDR;
                end
            end
            HDR, SEQ, DATA, CSUM: begin
                if (emit) begin
                    state_next = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_next = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    case (ret_state)
                        HDR:     state_next = SEQ;
                        SEQ:     state_next = DATA;
                        DATA:    state_next = (sample_cnt == LAST_SAMPLE) ? CSUM : DATA;
                        CSUM: begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            fifo_level <= '0;
            drop_count <= 8'h00;
            frame_done <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            seq_cnt    <= 8'h00;
            csum       <= 8'h00;
            sample_cnt <= '0;
            ret_state  <= IDLE;
        end else begin
            tx_start   <= emit;
            frame_done <= done_next;
            fifo_level <= level_next;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (sample_valid && full && drop_count != 8'hFF) begin
                drop_count <= drop_count + 1'b1;
            end
            if (done_next) begin
                seq_cnt <= seq_cnt + 1'b1;
            end
            if (emit) begin
                ret_state <= state;
                case (state)
                    HDR: tx_data <= HEADER;
                    SEQ: begin
                        tx_data <= seq_cnt;
                        csum    <= seq_cnt;
                    end
                    DATA: begin
                        tx_data <= mem[rd_ptr];
                        csum    <= csum ^ mem[rd_ptr];
                    end
                    CSUM:    tx_data <= csum;
                    default: tx_data <= tx_data;
                endcase
            end
            // The sample counter clears as the last sample's wait completes, i.e. on entering CSUM.
            if (wait_lo_exit && ret_state == DATA) begin
                sample_cnt <= (sample_cnt == LAST_SAMPLE) ? '0 : sample_cnt + 1'b1;
            end
        end
    end

    // NOTE: sample storage is not reset; the pointers and level alone define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sample_data;
        end
    end

endmodule
